// File: rtl/fft_input_framer_if.sv
// Sample-in / frame-out bus of the FFT input framer.
// Latency: none, wires only.
// Backpressure: carries in_valid/in_ready and frame_valid/frame_ready.
// Ports: in_valid/in_ready/in_real/in_imag form the sample stream; frame_valid/frame_ready/
// frame_real/frame_imag form the frame stream; frame_count is the release counter.
// Modports: master = the environment (sample source and frame consumer), slave = the framer.
interface fft_input_framer_if #(
    parameter int N      = 8,
    parameter int DATA_W = 16
);
    logic                       in_valid;
    logic                       in_ready;
    logic [DATA_W-1:0]          in_real;
    logic [DATA_W-1:0]          in_imag;
    logic                       frame_valid;
    logic                       frame_ready;
    logic [N-1:0][DATA_W-1:0]   frame_real;
    logic [N-1:0][DATA_W-1:0]   frame_imag;
    logic [15:0]                frame_count;

    modport master (
        output in_valid, in_real, in_imag, frame_ready,
        input  in_ready, frame_valid, frame_real, frame_imag, frame_count
    );

    modport slave (
        input  in_valid, in_real, in_imag, frame_ready,
        output in_ready, frame_valid, frame_real, frame_imag, frame_count
    );
endinterface

// File: rtl/fft_input_framer.sv
// Ping-pong framer: packs a complex sample stream into N-sample frames for the FFT core.
// Latency: frame_valid rises the cycle after the Nth sample of a frame is accepted.
// Backpressure: in_ready drops only while both banks hold unreleased frames.
// Ports: clk, rst (synchronous, active high); bus is the slave side of fft_input_framer_if.
module fft_input_framer #(
    parameter int N      = 8,
    parameter int DATA_W = 16,
    parameter int BITREV = 0
) (
    input  logic                clk,
    input  logic                rst,
    fft_input_framer_if.slave   bus
);
    localparam int              IDX_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    logic [DATA_W-1:0] re_q [2][N];
    logic [DATA_W-1:0] im_q [2][N];

    logic [1:0]       full_q, full_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [15:0]      frame_count_q, frame_count_d;

    logic             accept;
    logic             frame_done;
    logic             frame_rel;
    logic [IDX_W-1:0] wr_pos;

    logic [N-1:0][DATA_W-1:0] out_re;
    logic [N-1:0][DATA_W-1:0] out_im;

    function automatic logic [IDX_W-1:0] bitrev(input logic [IDX_W-1:0] v);
        logic [IDX_W-1:0] r;
        for (int k = 0; k < IDX_W; k++) begin
            r[k] = v[IDX_W-1-k];
        end
        return r;
    endfunction

    // The write bank is never full while being written, so in_ready only
    // depends on registered state.
    assign bus.in_ready    = !full_q[wr_bank_q];
    assign bus.frame_valid = full_q[rd_bank_q];
    assign bus.frame_count = frame_count_q;

    assign accept     = bus.in_valid && !full_q[wr_bank_q];
    assign frame_done = accept && (wr_idx_q == LAST_IDX);
    assign frame_rel  = full_q[rd_bank_q] && bus.frame_ready;
    assign wr_pos     = (BITREV != 0) ? bitrev(wr_idx_q) : wr_idx_q;

    always_comb begin
        out_re = '0;
        out_im = '0;
        for (int k = 0; k < N; k++) begin
            out_re[k] = re_q[rd_bank_q][k];
            out_im[k] = im_q[rd_bank_q][k];
        end
    end

    assign bus.frame_real = out_re;
    assign bus.frame_imag = out_im;

    // Completion and release always hit different banks, so both updates
    // to full can be applied independently in the same cycle.
    always_comb begin
        full_d        = full_q;
        wr_bank_d     = wr_bank_q;
        rd_bank_d     = rd_bank_q;
        wr_idx_d      = wr_idx_q;
        frame_count_d = frame_count_q;
        if (accept) begin
            wr_idx_d = wr_idx_q + IDX_W'(1);
        end
        if (frame_done) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = !wr_bank_q;
            wr_idx_d          = '0;
        end
        if (frame_rel) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
            frame_count_d     = frame_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q        <= '0;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            wr_idx_q      <= '0;
            frame_count_q <= '0;
        end else begin
            full_q        <= full_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            wr_idx_q      <= wr_idx_d;
            frame_count_q <= frame_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < N; k++) begin
                    re_q[b][k] <= '0;
                    im_q[b][k] <= '0;
                end
            end
        end else if (accept) begin
            re_q[wr_bank_q][wr_pos] <= bus.in_real;
            im_q[wr_bank_q][wr_pos] <= bus.in_imag;
        end
    end
endmodule

// File: tb/tb_fft_input_framer.sv
`timescale 1ns/1ps
module tb_fft_input_framer;
    localparam int N = 8;
    localparam int W = 16;
    typedef logic [N-1:0][W-1:0] frame_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         frame_ready = 1'b0;
    logic [W-1:0] in_real = '0;
    logic [W-1:0] in_imag = '0;

    always #5 clk = ~clk;

    fft_input_framer_if #(.N(N), .DATA_W(W)) bus0 ();
    fft_input_framer_if #(.N(N), .DATA_W(W)) bus1 ();

    assign bus0.in_valid    = in_valid;
    assign bus0.in_real     = in_real;
    assign bus0.in_imag     = in_imag;
    assign bus0.frame_ready = frame_ready;
    assign bus1.in_valid    = in_valid;
    assign bus1.in_real     = in_real;
    assign bus1.in_imag     = in_imag;
    assign bus1.frame_ready = frame_ready;

    fft_input_framer #(.N(N), .DATA_W(W), .BITREV(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    fft_input_framer #(.N(N), .DATA_W(W), .BITREV(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int n_vec = 0;
    int n_err = 0;

    // Reference model: completed frames waiting for the consumer, in arrival order.
    frame_t exp_re[$];
    frame_t exp_im[$];
    frame_t cur_re, cur_im;
    int     cur_cnt = 0;
    int     rel_cnt = 0;
    int     pend;
    logic   m_acc, m_rel;
    int     brev [N] = '{0, 4, 2, 6, 1, 5, 3, 7};

    task automatic chk(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Frame position k holds the sample that arrived at bit-reversed index k.
    function automatic frame_t perm(input frame_t f);
        frame_t r;
        for (int k = 0; k < N; k++) r[k] = f[brev[k]];
        return r;
    endfunction

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            exp_re.delete();
            exp_im.delete();
            cur_cnt = 0;
            rel_cnt = 0;
        end else begin
            pend  = exp_re.size();
            m_acc = in_valid && (pend < 2);
            m_rel = (pend > 0) && frame_ready;
            chk("in_ready0", bus0.in_ready, pend < 2);
            chk("in_ready1", bus1.in_ready, pend < 2);
            chk("frame_valid0", bus0.frame_valid, pend > 0);
            chk("frame_valid1", bus1.frame_valid, pend > 0);
            chk("frame_count0", bus0.frame_count, 16'(rel_cnt));
            chk("frame_count1", bus1.frame_count, 16'(rel_cnt));
            if (pend > 0) begin
                chk("frame_real0", bus0.frame_real, exp_re[0]);
                chk("frame_imag0", bus0.frame_imag, exp_im[0]);
                chk("frame_real1", bus1.frame_real, perm(exp_re[0]));
                chk("frame_imag1", bus1.frame_imag, perm(exp_im[0]));
            end
            if (m_rel) begin
                void'(exp_re.pop_front());
                void'(exp_im.pop_front());
                rel_cnt++;
            end
            if (m_acc) begin
                cur_re[cur_cnt] = in_real;
                cur_im[cur_cnt] = in_imag;
                cur_cnt++;
                if (cur_cnt == N) begin
                    exp_re.push_back(cur_re);
                    exp_im.push_back(cur_im);
                    cur_cnt = 0;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic push(input logic [W-1:0] re, input logic [W-1:0] im, input bit rnd_fr);
        bit took;
        took     = 1'b0;
        in_valid = 1'b1;
        in_real  = re;
        in_imag  = im;
        for (int w = 0; w < 50 && !took; w++) begin
            if (rnd_fr) frame_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            took = bus0.in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!took) begin
            n_vec++;
            n_err++;
            $display("FAIL push_timeout: sample %h not accepted in 50 cycles, required accept", re);
        end
    endtask

    task automatic chk_zero(input string tag);
        @(negedge clk);
        chk({tag, "_in_ready0"}, bus0.in_ready, 1'b1);
        chk({tag, "_in_ready1"}, bus1.in_ready, 1'b1);
        chk({tag, "_frame_valid0"}, bus0.frame_valid, 1'b0);
        chk({tag, "_frame_valid1"}, bus1.frame_valid, 1'b0);
        chk({tag, "_count0"}, bus0.frame_count, 16'd0);
        chk({tag, "_real0"}, bus0.frame_real, '0);
        chk({tag, "_imag0"}, bus0.frame_imag, '0);
        chk({tag, "_real1"}, bus1.frame_real, '0);
        chk({tag, "_imag1"}, bus1.frame_imag, '0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held two cycles.
        do_reset(2);
        chk_zero("reset");

        // Single frame, consumer always ready.
        frame_ready = 1'b1;
        for (int i = 1; i <= N; i++) push(16'(i), 16'(-i), 1'b0);
        idle(3);
        chk("single_count", bus0.frame_count, 16'd1);

        // Ramp 0..7: bit-reversed instance must show {0,4,2,6,1,5,3,7}.
        for (int i = 0; i < N; i++) push(16'(i), 16'($urandom), 1'b0);
        idle(3);
        chk("bitrev_count", bus1.frame_count, 16'd2);

        // Backpressure: both banks fill, sample 17 stalls until one release.
        do_reset(1);
        frame_ready = 1'b0;
        for (int i = 1; i <= 16; i++) push(16'(i), 16'(100 + i), 1'b0);
        in_valid = 1'b1;
        in_real  = 16'd17;
        in_imag  = 16'd117;
        idle(3);
        chk("bp_stalled", bus0.in_ready, 1'b0);
        frame_ready = 1'b1;
        idle(1);
        frame_ready = 1'b0;
        chk("bp_ready_back", bus0.in_ready, 1'b1);
        chk("bp_valid_held", bus0.frame_valid, 1'b1);
        for (int i = 17; i <= 20; i++) push(16'(i), 16'(100 + i), 1'b0);
        frame_ready = 1'b1;
        idle(6);
        chk("bp_count", bus0.frame_count, 16'd2);

        // 64 random samples with random input gaps.
        do_reset(1);
        frame_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            idle($urandom_range(0, 2));
            push(16'($urandom), 16'($urandom), 1'b0);
        end
        idle(4);
        chk("stream_count", bus0.frame_count, 16'd8);

        // Random consumer stalls.
        do_reset(1);
        for (int i = 0; i < 160; i++) push(16'($urandom), 16'($urandom), 1'b1);
        frame_ready = 1'b1;
        idle(6);
        chk("soak_count", bus0.frame_count, 16'd20);

        // Reset mid-fill discards the partial frame.
        do_reset(1);
        for (int i = 0; i < 5; i++) push(16'(16'h0500 + i), 16'(16'h0A00 + i), 1'b0);
        do_reset(1);
        chk_zero("midfill");
        for (int i = 0; i < N; i++) push(16'(16'h1000 + i), 16'(16'h2000 + i), 1'b0);
        idle(4);
        chk("midfill_count", bus0.frame_count, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fft_input_framer.md
# fft_input_framer

Upstream feeder for the 8-point FFT core. It accepts a stream of complex Q15 samples, one per cycle, under a valid/ready handshake. It assembles them into N-sample frames in a ping-pong (double) buffer and presents each complete frame as parallel `frame_real`/`frame_imag` vectors with a frame valid/ready handshake. One bank fills while the other is held for the FFT, so input streaming continues without a gap as long as the FFT consumes a frame within N cycles.

## Interface
- `N`, default 8: frame length in samples; power of two, 2..64.
- `DATA_W`, default 16: sample width per component, signed Q15 at 16.
- `BITREV`, default 0: 0 stores sample n at frame position n; 1 stores it at position bitrev(n) over log2(N) bits.

- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input sample present.
- `in_ready`  out  1  framer can accept a sample this cycle.
- `in_real`  in  DATA_W signed  sample real part.
- `in_imag`  in  DATA_W signed  sample imaginary part.
- `frame_valid`  out  1  a complete frame is presented.
- `frame_ready`  in  1  consumer takes the frame this cycle.
- `frame_real`  out  N x DATA_W signed  frame real parts, index 0..N-1.
- `frame_imag`  out  N x DATA_W signed  frame imaginary parts.
- `frame_count`  out  16  number of frames released since reset; wraps 0xFFFF to 0.

## Operation
- Storage: two banks (0, 1), each holding N complex registers.
- Per-bank state: `full[b]`.
- Write side: `wr_bank`, `wr_idx` (0..N-1).
- Read side: `rd_bank`.
- Input accept = `in_valid && in_ready`.
- `in_ready = !full[wr_bank]`. This is combinational from registers only and never depends on `in_valid` or `frame_ready`.
- On accept:
  - the sample is written to `bank[wr_bank][BITREV ? bitrev(wr_idx) : wr_idx]`;
  - `wr_idx` increments.
- On accept with `wr_idx == N-1`:
  - `full[wr_bank] <= 1`;
  - `wr_bank` toggles;
  - `wr_idx <= 0`.
- `frame_valid = full[rd_bank]`.
- `frame_real`/`frame_imag` are the contents of `bank[rd_bank]`, muxed from registers with no arithmetic.
- Frame release = `frame_valid && frame_ready`. On release:
  - `full[rd_bank] <= 0`;
  - `rd_bank` toggles;
  - `frame_count` increments.
- Simultaneous frame completion and frame release on different banks: both take effect in the same cycle.
- Completion and release always target different banks, because the write bank is never full while being written.
- Frame order is strict FIFO: frames are released in completion order and are never dropped or overwritten.
- `in_valid` low: no state change on the write side. Gaps inside a frame are allowed.
- Data is not modified: no scaling, rounding or sign extension.

## Timing
- Reset values (cycle after `rst` is sampled high):
  - `in_ready` = 1, `frame_valid` = 0, `frame_count` = 0;
  - `wr_bank` = 0, `rd_bank` = 0, `wr_idx` = 0;
  - both `full` = 0, all bank registers = 0, so `frame_real`/`frame_imag` read 0.
- Reset mid-frame discards the partial frame and any held frames. The next accepted sample goes to index 0 of bank 0.
- Latency: Nth sample accepted at edge t → `frame_valid` = 1 in the cycle following edge t.
- `frame_valid` and the frame data stay stable until the release edge.
- The new frame (if any) is visible in the cycle after release.
- Throughput: 1 sample/cycle is sustained indefinitely if each frame is released within N cycles of becoming valid.
- Both banks full:
  - `in_ready` = 0 and input stalls;
  - after a release, `in_ready` returns to 1 in the next cycle.
- `frame_ready` high while `frame_valid` = 0 has no effect.

## Test plan
- Reset: hold `rst` 2 cycles, then check `in_ready` = 1, `frame_valid` = 0, `frame_count` = 0, all frame words 0.
- Single frame, BITREV=0: stream real 1..8 / imag -1..-8 on consecutive cycles with `frame_ready` = 1 → `frame_valid` high exactly 1 cycle after the 8th sample, with `frame_real` = {1..8} and `frame_imag` = {-1..-8}; `frame_count` = 1 the cycle after.
- BITREV=1: stream real 0..7 → `frame_real` = {0,4,2,6,1,5,3,7}.
- Backpressure: `frame_ready` = 0, offer 20 samples → `in_ready` drops after the 16th accept and sample 17 is not taken. Then pulse `frame_ready` 1 cycle → frame {1..8} released, `in_ready` high the next cycle, `frame_valid` still 1 with {9..16}.
- Continuous stream of 64 samples with `frame_ready` = 1 and random `in_valid` gaps → 8 frames in order, data matches reference model, `frame_count` = 8, no accept lost.
- Reset mid-fill: accept 5 samples, assert `rst`, then stream 8 new samples → only one frame appears, containing the 8 new samples.
